queue_dispatcher: RTL and testbench

//  Write-side counterpart of the weighted round-robin read arbiter.
//  - Accepts a word stream via valid/ready.
//  - Decodes the destination queue from the word's top bits.
//  - Pushes the word into one of QUEUE_QUANTITY FIFOs, honouring buf_full and almost_full.
//  - A word blocked for STALL_LIMIT cycles is dropped and counted, so one stuck queue cannot stall the others.

---
 rtl/queue_dispatcher_pkg.sv | 14 +
 rtl/dispatcher_stall_timer.sv | 40 ++++
 rtl/queue_dispatcher.sv | 95 +++++++++
 tb/tb_queue_dispatcher.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_dispatcher_pkg.sv
// Shared types and constants for the queue dispatcher: FSM state encoding and drop counter sizing.
package queue_dispatcher_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StStall = 2'd2,
    StDrop  = 2'd3
  } state_e;

  localparam int unsigned DropCntBits = 8;
  localparam logic [DropCntBits-1:0] DropCntMax = '1;

endpackage

// File: rtl/dispatcher_stall_timer.sv
// Counts consecutive blocked cycles of the held word and keeps the saturating drop counter.
module dispatcher_stall_timer
  import queue_dispatcher_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic                   blocked,
  input  logic                   drop,
  output logic                   limit_hit,
  output logic [DropCntBits-1:0] drop_count
);

  localparam int unsigned CntBits = $clog2(STALL_LIMIT + 1);
  localparam logic [CntBits-1:0] CntMax = CntBits'(STALL_LIMIT);

  logic [CntBits-1:0] stall_cnt;

  // Asserted on the blocked cycle that would bring the count up to the limit.
  assign limit_hit = blocked && ((32'(stall_cnt) + 32'd1) >= STALL_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      drop_count <= '0;
    end else if (enb) begin
      if (!blocked) begin
        stall_cnt <= '0;
      end else if (stall_cnt != CntMax) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (drop && (drop_count != DropCntMax)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_dispatcher.sv
// Routes a valid/ready word stream into one of several FIFOs by its top bits, dropping words
// that stay blocked too long so a single stuck queue cannot stall the stream.
module queue_dispatcher
  import queue_dispatcher_pkg::*;
#(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STALL_LIMIT    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic                      in_valid,
  input  logic [DATA_BITS-1:0]      in_data,
  output logic                      in_ready,
  input  logic [QUEUE_QUANTITY-1:0] buf_full,
  input  logic [QUEUE_QUANTITY-1:0] almost_full,
  output logic [QUEUE_QUANTITY-1:0] push,
  output logic [DATA_BITS-1:0]      out_data,
  output logic [DropCntBits-1:0]    drop_count,
  output logic                      drop_pulse
);

  localparam int unsigned SEL_BITS = $clog2(QUEUE_QUANTITY);

  state_e              state_q;
  logic [DATA_BITS-1:0] h_data_q;
  logic [SEL_BITS-1:0] h_dest_q;
  logic [SEL_BITS-1:0] last_dest_q;
  logic                last_dest_vld_q;

  logic h_valid, af_block, push_ok, accept, blocked, limit_hit;

  assign h_valid  = (state_q == StHold) || (state_q == StStall);
  // Never push twice in a row into an almost-full FIFO: keeps one slot of margin.
  assign af_block = almost_full[h_dest_q] & last_dest_vld_q & (last_dest_q == h_dest_q);
  assign push_ok  = h_valid & enb & ~rst & ~buf_full[h_dest_q] & ~af_block;
  assign in_ready = enb & ~rst & (state_q != StDrop) & (~h_valid | push_ok);
  assign accept   = in_valid & in_ready;
  assign blocked  = h_valid & ~push_ok;

  assign out_data   = rst ? '0 : h_data_q;
  assign drop_pulse = enb & ~rst & (state_q == StDrop);

  always_comb begin
    push           = '0;
    push[h_dest_q] = push_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      h_data_q        <= '0;
      h_dest_q        <= '0;
      last_dest_q     <= '0;
      last_dest_vld_q <= 1'b0;
    end else if (enb) begin
      last_dest_vld_q <= push_ok;
      last_dest_q     <= h_dest_q;
      if (accept) begin
        h_data_q <= in_data;
        h_dest_q <= in_data[DATA_BITS-1 -: SEL_BITS];
      end
      case (state_q)
        StIdle: begin
          if (accept) state_q <= StHold;
        end
        StHold, StStall: begin
          if (push_ok)        state_q <= accept ? StHold : StIdle;
          else if (limit_hit) state_q <= StDrop;
          else                state_q <= StStall;
        end
        StDrop: begin
          state_q  <= StIdle;
          h_data_q <= '0;
          h_dest_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  dispatcher_stall_timer #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_timer (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .blocked   (blocked),
    .drop      (drop_pulse),
    .limit_hit (limit_hit),
    .drop_count(drop_count)
  );

endmodule

// File: tb/tb_queue_dispatcher.sv
// Bench for queue_dispatcher: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a word-level reference model.
module tb_queue_dispatcher;

  localparam int unsigned QQ    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned LIMIT = 8;

  logic          clk, rst, enb, in_valid, in_ready, drop_pulse;
  logic [DW-1:0] in_data, out_data;
  logic [QQ-1:0] buf_full, almost_full, push;
  logic [7:0]    drop_count;

  queue_dispatcher #(
    .QUEUE_QUANTITY(QQ),
    .DATA_BITS     (DW),
    .STALL_LIMIT   (LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .buf_full   (buf_full),
    .almost_full(almost_full),
    .push       (push),
    .out_data   (out_data),
    .drop_count (drop_count),
    .drop_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: at most one word waiting, how long it has waited, pending drop, last push.
  logic          m_have = 1'b0, m_dropping = 1'b0, m_last_vld = 1'b0;
  logic [DW-1:0] m_word = '0;
  logic [1:0]    m_last = '0;
  int            m_age = 0;
  int            m_count = 0;

  logic [QQ-1:0] s_push;
  logic          s_ready, s_dp;
  logic [7:0]    s_dc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    logic [QQ-1:0] e_push;
    logic          e_ready, e_dp, can, acc;
    logic [1:0]    d;
    @(negedge clk);
    d = m_word[DW-1 -: 2];
    e_push = '0; e_ready = 1'b0; e_dp = 1'b0; can = 1'b0;
    if (!rst && enb) begin
      if (m_dropping) begin
        e_dp = 1'b1;
      end else begin
        can = m_have && !buf_full[d] && !(almost_full[d] && m_last_vld && m_last == d);
        if (can) e_push[d] = 1'b1;
        e_ready = !m_have || can;
      end
    end
    chk("push", 32'(push), 32'(e_push));
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("drop_pulse", 32'(drop_pulse), 32'(e_dp));
    chk("drop_count", 32'(drop_count), 32'(m_count));
    if (rst) chk("out_data_rst", 32'(out_data), 32'd0);
    else if (m_have) chk("out_data", 32'(out_data), 32'(m_word));
    s_push = push; s_ready = in_ready; s_dp = drop_pulse; s_dc = drop_count;
    @(posedge clk);
    acc = in_valid && e_ready;
    if (rst) begin
      m_have = 1'b0; m_dropping = 1'b0; m_last_vld = 1'b0; m_age = 0; m_count = 0;
    end else if (enb) begin
      m_last_vld = can;
      if (can) m_last = d;
      if (m_dropping) begin
        m_dropping = 1'b0;
        if (m_count < 255) m_count++;
      end else if (can) begin
        m_have = 1'b0; m_age = 0;
      end else if (m_have) begin
        m_age++;
        if (m_age == int'(LIMIT)) begin
          m_have = 1'b0; m_dropping = 1'b1; m_age = 0;
        end
      end
      if (acc) begin
        m_have = 1'b1; m_word = in_data; m_age = 0;
      end
    end
    cyc++;
    #1;
  endtask

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic [QQ-1:0] full;
    logic [QQ-1:0] af;
    logic [QQ-1:0] exp_push;
    logic          exp_ready;
  } vec_t;

  vec_t vecs[17];
  int   first, prev, gap, npulse;
  logic pending;

  initial begin
    rst = 1'b1; enb = 1'b1; in_valid = 1'b0; in_data = '0; buf_full = '0; almost_full = '0;

    // Stream to all four queues, then almost-full spacing, then a short buf_full stall.
    vecs[0]  = '{1'b1, 8'h05, 4'h0, 4'h0, 4'b0000, 1'b1};
    vecs[1]  = '{1'b1, 8'h4A, 4'h0, 4'h0, 4'b0001, 1'b1};
    vecs[2]  = '{1'b1, 8'h8C, 4'h0, 4'h0, 4'b0010, 1'b1};
    vecs[3]  = '{1'b1, 8'hC3, 4'h0, 4'h0, 4'b0100, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 4'h0, 4'h0, 4'b1000, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 4'h0, 4'h0, 4'b0000, 1'b1};
    vecs[6]  = '{1'b1, 8'h40, 4'h0, 4'h2, 4'b0000, 1'b1};
    vecs[7]  = '{1'b1, 8'h41, 4'h0, 4'h2, 4'b0010, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 4'h0, 4'h2, 4'b0000, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 4'h0, 4'h2, 4'b0010, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 4'h0, 4'h0, 4'b0000, 1'b1};
    vecs[11] = '{1'b1, 8'h80, 4'h0, 4'h0, 4'b0000, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 4'h4, 4'h0, 4'b0000, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 4'h4, 4'h0, 4'b0000, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 4'h4, 4'h0, 4'b0000, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 4'h0, 4'h0, 4'b0100, 1'b1};
    vecs[16] = '{1'b0, 8'h00, 4'h0, 4'h0, 4'b0000, 1'b1};

    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_ready", 32'(s_ready), 32'd1);
    chk("reset_drop_count", 32'(s_dc), 32'd0);

    foreach (vecs[i]) begin
      in_valid = vecs[i].valid; in_data = vecs[i].data;
      buf_full = vecs[i].full; almost_full = vecs[i].af;
      cycle();
      chk($sformatf("vec%0d_push", i), 32'(s_push), 32'(vecs[i].exp_push));
      chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_dc", i), 32'(s_dc), 32'd0);
    end

    // Stuck queue: word is dropped after LIMIT blocked cycles.
    in_valid = 1'b1; in_data = 8'hFF; buf_full = 4'b1000;
    cycle();
    in_valid = 1'b0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (s_dp && first == 0) first = k;
      if (first != 0) break;
    end
    chk("drop_latency", 32'(first), 32'(LIMIT + 1));
    cycle();
    chk("ready_after_drop", 32'(s_ready), 32'd1);
    chk("count_after_drop", 32'(s_dc), 32'd1);

    // Freeze mid-stall with enb low, then finish the count.
    in_valid = 1'b1; in_data = 8'hC0;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    enb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("enb0_pulse", 32'(s_dp), 32'd0);
      chk("enb0_ready", 32'(s_ready), 32'd0);
    end
    enb = 1'b1;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (s_dp && first == 0) first = k;
      if (first != 0) break;
    end
    chk("drop_after_enb", 32'(first), 32'd4);
    cycle();
    chk("count_after_enb", 32'(s_dc), 32'd2);

    // Blocked word freed on the cycle it would otherwise hit the limit: push wins.
    in_valid = 1'b1; in_data = 8'h80; buf_full = 4'b0100;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < int'(LIMIT) - 1; k++) cycle();
    buf_full = 4'b0000;
    cycle();
    chk("limit_push", 32'(s_push), 32'b0100);
    chk("limit_no_drop", 32'(s_dp), 32'd0);
    cycle();
    chk("limit_count", 32'(s_dc), 32'd2);

    // Reset while a word is stalled: discarded, not counted.
    in_valid = 1'b1; in_data = 8'h40; buf_full = 4'b0010;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    rst = 1'b1;
    cycle();
    chk("rst_push", 32'(s_push), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_ready", 32'(s_ready), 32'd1);
    chk("post_rst_count", 32'(s_dc), 32'd0);
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (s_dp) npulse++;
    end
    chk("post_rst_no_drop", 32'(npulse), 32'd0);
    buf_full = '0;

    // Randomized traffic; producer holds the word while it is not accepted.
    pending = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      enb = ($urandom_range(0, 7) != 0);
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = DW'($urandom);
      end
      buf_full    = QQ'($urandom & $urandom & $urandom);
      almost_full = QQ'($urandom & $urandom);
      cycle();
      pending = in_valid && !s_ready && !rst;
    end

    // Every queue full: steady drop cadence and counter saturation.
    rst = 1'b1; enb = 1'b1; in_valid = 1'b0; buf_full = '1; almost_full = '0;
    cycle();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h7E;
    npulse = 0; prev = 0; gap = 0;
    for (int k = 0; k < 256 * int'(LIMIT + 2) + 40; k++) begin
      cycle();
      if (s_dp) begin
        npulse++;
        if (npulse == 3) gap = cyc - prev;
        prev = cyc;
      end
    end
    chk("drop_interval", 32'(gap), 32'(LIMIT + 2));
    chk("count_saturated", 32'(s_dc), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
